// File: rtl/aes_mcol_seq.sv
// Iterative MixColumns: one column per clock through a shared log/antilog GF(2^8) mixer.
// Optional inverse mode (InvMixColumns) enabled by defining AES_MCOL_INV_EN.
module aes_mcol_seq #(
    parameter  int NB = 4,
    localparam int CW = (NB > 1) ? $clog2(NB) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*NB-1:0][7:0]  State_in,
    input  logic [255:0][7:0]     EXP3,
    input  logic [255:0][7:0]     LN3,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*NB-1:0][7:0]  State_out,
    output logic [CW-1:0]         col_idx,
    output logic                  busy
`ifdef AES_MCOL_INV_EN
    ,
    input  logic                  inv
`endif
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_t;

    fsm_t                  state_reg;
    logic [CW-1:0]         col_idx_reg;
    logic                  out_valid_reg;
    logic                  busy_reg;
    logic [4*NB-1:0][7:0]  in_buf_reg;
    logic [4*NB-1:0][7:0]  state_out_reg;
    logic                  accept;

    logic [3:0][7:0]       cur_col;
    logic [3:0][7:0]       mix_col;
    logic [3:0][7:0]       ln_col;
    logic [3:0][7:0]       base_coef;

`ifdef AES_MCOL_INV_EN
    logic                  inv_reg;
`endif

    assign in_ready  = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_reg;
    assign busy      = busy_reg;
    assign col_idx   = col_idx_reg;
    assign State_out = state_out_reg;

    assign cur_col = in_buf_reg[4*int'(col_idx_reg) +: 4];

    // Row 0 coefficients; row r uses them rotated right by r.
    always_comb begin
        base_coef = {8'h01, 8'h01, 8'h03, 8'h02};
`ifdef AES_MCOL_INV_EN
        if (inv_reg) begin
            base_coef = {8'h09, 8'h0d, 8'h0b, 8'h0e};
        end
`endif
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ln
            assign ln_col[gi] = LN3[cur_col[gi]];
        end

        for (gi = 0; gi < 4; gi++) begin : g_row
            logic [7:0] row_out;

            always_comb begin
                logic [7:0] acc;
                logic [7:0] coef;
                logic [7:0] prod;
                logic [8:0] sum;
                logic [1:0] k;
                acc  = 8'h00;
                coef = 8'h00;
                prod = 8'h00;
                sum  = 9'd0;
                k    = 2'd0;
                for (int j = 0; j < 4; j++) begin
                    k    = 2'(j - gi);
                    coef = base_coef[k];
                    // Log sum modulo 255: 255 itself folds back to exponent 0.
                    sum  = {1'b0, LN3[coef]} + {1'b0, ln_col[j]};
                    if (sum >= 9'd255) begin
                        sum = sum - 9'd255;
                    end
                    if (coef == 8'h01) begin
                        prod = cur_col[j];
                    end else if (cur_col[j] == 8'h00) begin
                        prod = 8'h00;
                    end else begin
                        prod = EXP3[sum[7:0]];
                    end
                    acc = acc ^ prod;
                end
                row_out = acc;
            end

            assign mix_col[gi] = row_out;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            col_idx_reg   <= '0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            in_buf_reg    <= '0;
            state_out_reg <= '0;
`ifdef AES_MCOL_INV_EN
            inv_reg       <= 1'b0;
`endif
        end else begin
            case (state_reg)
                BUSY: begin
                    state_out_reg[4*int'(col_idx_reg) +: 4] <= mix_col;
                    if (col_idx_reg == CW'(NB - 1)) begin
                        col_idx_reg   <= '0;
                        state_reg     <= DONE;
                        busy_reg      <= 1'b0;
                        out_valid_reg <= 1'b1;
                    end else begin
                        col_idx_reg <= col_idx_reg + 1'b1;
                    end
                end
                IDLE, DONE: begin
                    if (state_reg == DONE && out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                    if (accept) begin
                        in_buf_reg    <= State_in;
`ifdef AES_MCOL_INV_EN
                        inv_reg       <= inv;
`endif
                        col_idx_reg   <= '0;
                        state_reg     <= BUSY;
                        busy_reg      <= 1'b1;
                        out_valid_reg <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
